// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit frame controller: FSM states, line-mux selects, default width.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
// Build option UART_TX_TWO_STOP_EN adds the STOP2 state (second stop bit).
package uart_tx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`endif

    // Line mux select; the start/stop encodings double as the bit value driven.
    typedef enum logic [1:0] {
        MUX_START_BIT = 2'd0,
        MUX_STOP_BIT  = 2'd1,
        MUX_DATA      = 2'd2,
        MUX_PARITY    = 2'd3
    } mux_sel_t;

    // Which source the line carries while the FSM sits in a given state.
    // IDLE and every stop state drive the idle/stop level (1).
    function automatic mux_sel_t state_mux_sel(input tx_state_t st);
        case (st)
            ST_START:  return MUX_START_BIT;
            ST_DATA:   return MUX_DATA;
            ST_PARITY: return MUX_PARITY;
            default:   return MUX_STOP_BIT;
        endcase
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Parity of one data word: even = XOR of all bits, odd = XNOR of all bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: data (DATA_WIDTH) and par_typ (0 even, 1 odd) in; parity_bit out.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    // XNOR-reduce equals XOR-reduce inverted, so odd parity is a single XOR with par_typ.
    assign parity_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, serializer data, optional parity, stop bit(s) onto TX_OUT.
// Latency: TX_OUT/Busy lag the FSM state by one SER_CLK; 10 cycles/frame (11 with parity, +1 with two stops).
// Backpressure: Data_Valid is accepted only in IDLE or the final stop state; requests at other times are dropped.
// Ports: SER_CLK, SER_RST (async active-low); P_DATA/Data_Valid/PAR_EN/PAR_TYP request; ser_done/ser_data from
//        the serializer; ser_en to the serializer; TX_OUT serial line (idle high); Busy frame in progress.
// Build option UART_TX_TWO_STOP_EN adds a second stop bit and moves the back-to-back accept to STOP2.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  SER_CLK,
    input  logic                  SER_RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bit;
    mux_sel_t              mux_sel;
    logic                  line_bit;

    // Parity always comes from the byte latched at accept, never from live P_DATA.
    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data       (data_q),
        .par_typ    (par_typ_q),
        .parity_bit (par_bit)
    );

    // Serializer runs only in START/DATA; low elsewhere lets it reload P_DATA.
    assign ser_en  = (state == ST_START) || (state == ST_DATA);
    assign mux_sel = state_mux_sel(state);

    always_comb begin
        line_bit = 1'b1;
        case (mux_sel)
            MUX_START_BIT: line_bit = 1'b0;
            MUX_STOP_BIT:  line_bit = 1'b1;
            MUX_DATA:      line_bit = ser_data;
            MUX_PARITY:    line_bit = par_bit;
            default:       line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge SER_CLK or negedge SER_RST) begin
        if (!SER_RST) begin
            state     <= ST_IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            // Registered copies of the current state's line value: one-cycle lag behind state.
            TX_OUT <= line_bit;
            Busy   <= (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (Data_Valid) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        state     <= ST_START;
                    end
                end
                ST_START: state <= ST_DATA;
                ST_DATA: begin
                    // ser_done marks the cycle carrying the last data bit.
                    if (ser_done) begin
                        state <= par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: state <= ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
                ST_STOP: state <= ST_STOP2;
                ST_STOP2: begin
`else
                ST_STOP: begin
`endif
                    // Last stop bit: a waiting request starts the next frame with no idle gap.
                    if (Data_Valid) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        state     <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif

    logic       SER_CLK = 1'b0;
    logic       SER_RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_done;
    logic       ser_data;
    logic       ser_en;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    logic bit_q[$];
    int   len_q[$];
    int   busy_run = 0;

    always #5 SER_CLK = ~SER_CLK;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .SER_CLK    (SER_CLK),
        .SER_RST    (SER_RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // Serializer model: loads P_DATA while disabled, shifts out LSB first while enabled.
    logic [7:0] sreg;
    logic [3:0] scnt;
    always @(posedge SER_CLK or negedge SER_RST) begin
        if (!SER_RST) begin
            sreg     <= 8'h00;
            scnt     <= 4'd0;
            ser_data <= 1'b0;
        end else if (!ser_en) begin
            sreg <= P_DATA;
            scnt <= 4'd0;
        end else begin
            ser_data <= sreg[0];
            sreg     <= {1'b0, sreg[7:1]};
            scnt     <= scnt + 4'd1;
        end
    end
    assign ser_done = (scnt == 4'd8);

    // Monitor: pops one expected line bit per Busy cycle and one expected Busy length per frame.
    always @(negedge SER_CLK) begin
        logic e;
        int   l;
        if (!SER_RST) begin
            busy_run = 0;
        end else if (Busy) begin
            busy_run++;
            checks++;
            if (bit_q.size() == 0) begin
                errors++;
                $display("FAIL extra_busy_bit: TX_OUT=%b with Busy=1, no bit expected", TX_OUT);
            end else begin
                e = bit_q.pop_front();
                if (TX_OUT !== e) begin
                    errors++;
                    $display("FAIL tx_bit: got %b expected %b (bit %0d of run)", TX_OUT, e, busy_run);
                end
            end
        end else begin
            if (busy_run != 0) begin
                checks++;
                if (len_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_len: unexpected busy run of %0d cycles", busy_run);
                end else begin
                    l = len_q.pop_front();
                    if (busy_run != l) begin
                        errors++;
                        $display("FAIL busy_len: got %0d expected %0d", busy_run, l);
                    end
                end
                busy_run = 0;
            end
            checks++;
            if (TX_OUT !== 1'b1) begin
                errors++;
                $display("FAIL idle_line: TX_OUT=%b expected 1 while Busy=0", TX_OUT);
            end
        end
    end

    // Push a hand-written frame, leftmost bit first on the line, plus any extra stop bit.
    task automatic push_bits(input logic [11:0] frame, input int len);
        logic [11:0] f;
        f = frame;
        for (int i = len - 1; i >= 0; i--) bit_q.push_back(f[i]);
        for (int i = 0; i < XS; i++) bit_q.push_back(1'b1);
    endtask

    task automatic request(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge SER_CLK); #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((bit_q.size() != 0 || len_q.size() != 0 || Busy) && n < 300) begin
            @(posedge SER_CLK); #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: %0d bits still pending, Busy=%b", name, bit_q.size(), Busy);
        end
        @(posedge SER_CLK); #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0 || ser_en !== 1'b0) begin
            errors++;
            $display("FAIL %s: TX_OUT=%b Busy=%b ser_en=%b expected 1 0 0", name, TX_OUT, Busy, ser_en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset, then five idle cycles.
        SER_RST = 1'b0;
        repeat (2) @(posedge SER_CLK);
        #1;
        check_idle("reset_state");
        SER_RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge SER_CLK); #1;
            check_idle("idle_after_reset");
        end

        // 0xA5, even parity: parity bit 0.
        push_bits(12'b0000_0101_0010_1010 >> 0, 11);
        bit_q.delete();
        push_bits(12'b010100101010 >> 1, 11);
        len_q.push_back(11 + XS);
        request(8'hA5, 1'b1, 1'b0);
        wait_drain("a5_even");

        // 0xA5, odd parity: parity bit 1.
        push_bits(12'b010100101110 >> 1, 11);
        len_q.push_back(11 + XS);
        request(8'hA5, 1'b1, 1'b1);
        wait_drain("a5_odd");

        // 0x3C, no parity, Data_Valid held: two back-to-back frames, one unbroken Busy run.
        push_bits(12'b000111100100 >> 2, 10);
        push_bits(12'b000111100100 >> 2, 10);
        len_q.push_back(20 + 2 * XS);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(posedge SER_CLK);
        repeat (10 + XS) @(posedge SER_CLK);
        #1;
        Data_Valid = 1'b0;
        wait_drain("b2b_3c");

        // 0xC3 odd parity; mid-frame request of 0xFF with parity settings changed is ignored.
        push_bits(12'b011000011110 >> 1, 11);
        len_q.push_back(11 + XS);
        request(8'hC3, 1'b1, 1'b1);
        repeat (3) @(posedge SER_CLK);
        #1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(posedge SER_CLK); #1;
        Data_Valid = 1'b0;
        wait_drain("ignore_mid");
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL after_ignore: TX_OUT=%b Busy=%b expected 1 0", TX_OUT, Busy);
        end

        // Reset asserted while the 4th data bit of 0x3C is on the line.
        push_bits(12'b000111100100 >> 2, 10);
        len_q.push_back(10 + XS);
        request(8'h3C, 1'b0, 1'b0);
        repeat (6) @(posedge SER_CLK);
        #1;
        bit_q.delete();
        len_q.delete();
        SER_RST = 1'b0;
        #1;
        check_idle("async_reset");
        @(posedge SER_CLK); #1;
        check_idle("reset_held");
        SER_RST = 1'b1;
        @(posedge SER_CLK); #1;

        // Clean 0x55 frame after reset release, no parity.
        push_bits(12'b010101010100 >> 2, 10);
        len_q.push_back(10 + XS);
        request(8'h55, 1'b0, 1'b0);
        wait_drain("post_reset_55");
        check_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
